// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, loader-written instruction memory,
// stall hold, redirect with one-bubble flush, and HALT detection driving the IF/ID register.
module instruction_fetch #(
    parameter int                 NB_DATA  = 32,
    parameter int                 NB_ADDR  = 10,
    parameter logic [NB_DATA-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_load_en,
    input  logic [NB_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0] i_load_data,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_jump_addr,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pcounter4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam logic [NB_DATA-1:0] NOP       = '0;
    localparam logic [NB_DATA-1:0] HALT_WORD = '1;

    state_t             state;
    logic [NB_DATA-1:0] mem [2**NB_ADDR];
    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] fetch_word;

    // Fetch index ignores PC bits above the memory depth, so far targets alias.
    assign fetch_word = mem[pc[NB_ADDR+1:2]];
    assign pc_plus4   = pc + NB_DATA'(4);
    assign o_pc       = pc;

    // Memory is deliberately outside the reset domain so a program survives reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && i_load_en)
            mem[i_load_addr] <= i_load_data;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            o_instruction <= NOP;
            o_pcounter4   <= '0;
            o_halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_jump) begin
                        pc            <= {i_jump_addr[NB_DATA-1:2], 2'b00};
                        o_instruction <= NOP;
                        o_pcounter4   <= '0;
                    end else if (!i_stall) begin
                        o_instruction <= fetch_word;
                        o_pcounter4   <= pc_plus4;
                        // HALT is passed to decode once; PC parks on its address.
                        if (fetch_word == HALT_WORD) begin
                            state    <= ST_HALTED;
                            o_halted <= 1'b1;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                ST_HALTED: begin
                    o_instruction <= NOP;
                end
                default: begin
                    state         <= ST_IDLE;
                    pc            <= RESET_PC;
                    o_instruction <= NOP;
                    o_pcounter4   <= '0;
                    o_halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run sequencing, stall, redirect, wrap,
// HALT handling and reset replay against hand-computed IF/ID values.
module tb_instruction_fetch;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 10;

    localparam logic [31:0] WA = 32'h1111_1111;
    localparam logic [31:0] WB = 32'h2222_2222;
    localparam logic [31:0] WC = 32'h3333_3333;
    localparam logic [31:0] WD = 32'h4444_4444;
    localparam logic [31:0] WE = 32'h5555_5555;
    localparam logic [31:0] WT = 32'h7777_7777;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               load_en = 1'b0;
    logic [NB_ADDR-1:0] load_addr = '0;
    logic [NB_DATA-1:0] load_data = '0;
    logic               stall = 1'b0;
    logic               jump = 1'b0;
    logic [NB_DATA-1:0] jump_addr = '0;
    logic [NB_DATA-1:0] instruction;
    logic [NB_DATA-1:0] pcounter4;
    logic [NB_DATA-1:0] pc;
    logic               halted;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_load_en    (load_en),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .i_stall      (stall),
        .i_jump       (jump),
        .i_jump_addr  (jump_addr),
        .o_instruction(instruction),
        .o_pcounter4  (pcounter4),
        .o_pc         (pc),
        .o_halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full IF/ID register plus PC and halt flag in one go.
    task automatic chk_if(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic [31:0] p, input logic h);
        chk({tag, ".instr"}, instruction, ins);
        chk({tag, ".pc4"}, pcounter4, p4);
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = NB_ADDR'(addr);
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();

        load(0, WA); load(1, WB); load(2, WC); load(3, WD);
        load(4, WE); load(5, 32'h6666_6666); load(1023, WT);
        chk_if("idle_hold", 32'h0, 32'h0, 32'h0, 1'b0);

        // T1: sequential fetch
        go();
        chk_if("t1_start", 32'h0, 32'h0, 32'h0, 1'b0);
        tick(); chk_if("t1_a", WA, 32'd4, 32'd4, 1'b0);
        tick(); chk_if("t1_b", WB, 32'd8, 32'd8, 1'b0);
        tick(); chk_if("t1_c", WC, 32'd12, 32'd12, 1'b0);
        tick(); chk_if("t1_d", WD, 32'd16, 32'd16, 1'b0);
        tick(); chk_if("t1_e", WE, 32'd20, 32'd20, 1'b0);

        // T3: redirect with flush, alone and with simultaneous stall
        jump = 1'b1; jump_addr = 32'h0000_0013;
        tick(); jump = 1'b0;
        chk_if("t3_flush", 32'h0, 32'h0, 32'h10, 1'b0);
        tick(); chk_if("t3_tgt", WE, 32'h14, 32'h14, 1'b0);
        jump = 1'b1; stall = 1'b1;
        tick(); jump = 1'b0; stall = 1'b0;
        chk_if("t3_js_flush", 32'h0, 32'h0, 32'h10, 1'b0);
        tick(); chk_if("t3_js_tgt", WE, 32'h14, 32'h14, 1'b0);

        // T6: async reset mid-run, then replay without reload
        rst_n = 1'b0;
        #2;
        chk_if("t6_async", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();
        go();
        tick(); chk_if("t6_a", WA, 32'd4, 32'd4, 1'b0);

        // T2: stall holds for three cycles
        tick(); chk_if("t2_b", WB, 32'd8, 32'd8, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_if("t2_hold", WB, 32'd8, 32'd8, 1'b0);
        end
        stall = 1'b0;
        tick(); chk_if("t2_c", WC, 32'd12, 32'd12, 1'b0);

        // T5: fetch index wraps modulo memory depth
        jump = 1'b1; jump_addr = 32'h0000_1000;
        tick(); jump = 1'b0;
        chk_if("t5_flush", 32'h0, 32'h0, 32'h1000, 1'b0);
        tick(); chk_if("t5_wrap", WA, 32'h1004, 32'h1004, 1'b0);
        jump = 1'b1; jump_addr = 32'h0000_0FFC;
        tick(); jump = 1'b0;
        chk_if("t5_ffc", 32'h0, 32'h0, 32'hFFC, 1'b0);
        tick(); chk_if("t5_top", WT, 32'h1000, 32'h1000, 1'b0);
        tick(); chk_if("t5_inc_wrap", WA, 32'h1004, 32'h1004, 1'b0);

        // T4: HALT word at mem[2]
        do_reset();
        load(2, 32'hFFFF_FFFF);
        go();
        tick(); chk_if("t4_a", WA, 32'd4, 32'd4, 1'b0);
        tick(); chk_if("t4_b", WB, 32'd8, 32'd8, 1'b0);
        tick(); chk_if("t4_halt", 32'hFFFF_FFFF, 32'd12, 32'd8, 1'b1);
        tick(); chk_if("t4_nop", 32'h0, 32'd12, 32'd8, 1'b1);
        load(0, 32'hDEAD_BEEF);
        tick(); chk_if("t4_stay", 32'h0, 32'd12, 32'd8, 1'b1);

        // Jump in the HALT fetch cycle wins; memory still holds A after the HALTED load
        do_reset();
        go();
        tick(); chk_if("jh_a", WA, 32'd4, 32'd4, 1'b0);
        tick(); chk_if("jh_b", WB, 32'd8, 32'd8, 1'b0);
        jump = 1'b1; jump_addr = 32'h0000_0010;
        tick(); jump = 1'b0;
        chk_if("jh_redirect", 32'h0, 32'h0, 32'h10, 1'b0);
        tick(); chk_if("jh_e", WE, 32'h14, 32'h14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
